// File: rtl/segrunner_pkg.sv
// Shared login-path definitions: ROM arbiter state encoding, requester IDs and
// default user-ROM geometry.
package segrunner_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_ISSUE   = 2'd1;
  localparam logic [1:0] ARB_WAIT    = 2'd2;
  localparam logic [1:0] ARB_RESPOND = 2'd3;

  localparam logic REQ_ID = 1'b0;
  localparam logic REQ_PW = 1'b1;

  localparam int ROM_ADDR_W = 3;
  localparam int ROM_DATA_W = 16;

endpackage

// File: rtl/rom_access_arbiter_if.sv
// Bundle between the two login-path handlers, the ROM and rom_access_arbiter.
// slave = arbiter side, master = requesters plus ROM.
interface rom_access_arbiter_if
  import segrunner_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic              req0_ack;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic              req1_ack;
   logic              rsp0_valid;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              busy;

   modport slave (
      input  req0_valid, req0_addr, req1_valid, req1_addr, rom_data,
      output req0_ack, req1_ack, rsp0_valid, rsp1_valid, rsp_data,
             rom_en, rom_addr, busy
   );

   modport master (
      output req0_valid, req0_addr, req1_valid, req1_addr, rom_data,
      input  req0_ack, req1_ack, rsp0_valid, rsp1_valid, rsp_data,
             rom_en, rom_addr, busy
   );
endinterface

// File: rtl/rom_access_arbiter_picker.sv
// rom_arb_picker: combinational winner select for the ROM arbiter.
// ROM_ARB_RR_EN selects round-robin on a tie; otherwise requester 0 has fixed priority.
module rom_arb_picker
  import segrunner_pkg::*;
(
   input  logic req0Valid,
   input  logic req1Valid,
   input  logic lastOwner,
   output logic anyReq,
   output logic winner
);
   assign anyReq = req0Valid | req1Valid;

`ifdef ROM_ARB_RR_EN
   // NOTE: winner gets a default before any branch so no latch is inferred.
   always_comb begin
      winner = REQ_ID;
      if (req0Valid && req1Valid) winner = ~lastOwner;
      else if (req1Valid)         winner = REQ_PW;
   end
`else
   // Fixed priority never looks at history; the tap keeps the port consumed.
   logic unusedLastOwner;
   assign unusedLastOwner = lastOwner;

   always_comb begin
      winner = REQ_ID;
      if (req1Valid && !req0Valid) winner = REQ_PW;
   end
`endif
endmodule

// File: rtl/rom_access_arbiter.sv
// Shares the single-port synchronous user ROM between the ID and password handlers.
// Build option: define ROM_ARB_RR_EN for round-robin tie-break (default fixed priority).
module rom_access_arbiter
  import segrunner_pkg::*;
#(
   parameter int ADDR_W      = ROM_ADDR_W,
   parameter int DATA_W      = ROM_DATA_W,
   parameter int ROM_LATENCY = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   rom_access_arbiter_if.slave  bus
);
   localparam int CNT_W = 2;

   logic [1:0]        state;
   logic              owner;
   logic              lastOwner;
   logic [CNT_W-1:0]  latCnt;
   logic              ack0Q, ack1Q, romEnQ, rsp0Q, rsp1Q;
   logic [ADDR_W-1:0] romAddrQ;
   logic [DATA_W-1:0] rspDataQ;
   logic              anyReq, winner;

   rom_arb_picker uPicker (
      .req0Valid (bus.req0_valid),
      .req1Valid (bus.req1_valid),
      .lastOwner (lastOwner),
      .anyReq    (anyReq),
      .winner    (winner)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ARB_IDLE;
         owner     <= REQ_ID;
         lastOwner <= REQ_PW;
         latCnt    <= '0;
         ack0Q     <= 1'b0;
         ack1Q     <= 1'b0;
         romEnQ    <= 1'b0;
         rsp0Q     <= 1'b0;
         rsp1Q     <= 1'b0;
         romAddrQ  <= '0;
         rspDataQ  <= '0;
      end else begin
         ack0Q  <= 1'b0;
         ack1Q  <= 1'b0;
         romEnQ <= 1'b0;
         rsp0Q  <= 1'b0;
         rsp1Q  <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (anyReq) begin
                  owner     <= winner;
                  lastOwner <= winner;
                  romAddrQ  <= (winner == REQ_PW) ? bus.req1_addr : bus.req0_addr;
                  ack0Q     <= (winner == REQ_ID);
                  ack1Q     <= (winner == REQ_PW);
                  romEnQ    <= 1'b1;
                  state     <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               latCnt <= CNT_W'(ROM_LATENCY - 1);
               state  <= ARB_WAIT;
            end
            ARB_WAIT: begin
               // Counter reaches zero in the cycle the ROM word is valid.
               if (latCnt == '0) begin
                  rspDataQ <= bus.rom_data;
                  rsp0Q    <= (owner == REQ_ID);
                  rsp1Q    <= (owner == REQ_PW);
                  state    <= ARB_RESPOND;
               end else begin
                  latCnt <= latCnt - 1'b1;
               end
            end
            ARB_RESPOND: state <= ARB_IDLE;
            default:     state <= ARB_IDLE;
         endcase
      end
   end

   assign bus.req0_ack   = ack0Q;
   assign bus.req1_ack   = ack1Q;
   assign bus.rom_en     = romEnQ;
   assign bus.rom_addr   = romAddrQ;
   assign bus.rsp0_valid = rsp0Q;
   assign bus.rsp1_valid = rsp1Q;
   assign bus.rsp_data   = rspDataQ;
   assign bus.busy       = (state != ARB_IDLE);
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: one instance at ROM latency 1, one at 3.
// Tie-break expectations follow ROM_ARB_RR_EN.
module tb_rom_access_arbiter;
   import segrunner_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   totalCnt = 0;
   int   badCnt   = 0;

   always #5 clk = ~clk;

   rom_access_arbiter_if busA ();
   rom_access_arbiter_if busB ();

   rom_access_arbiter #(.ROM_LATENCY(1)) dutA (.clk(clk), .rst(rst), .bus(busA));
   rom_access_arbiter #(.ROM_LATENCY(3)) dutB (.clk(clk), .rst(rst), .bus(busB));

   function automatic logic [15:0] romWord(input int a);
      if (a == 5) return 16'h1234;
      return 16'hA000 + 16'(a * 'h0111);
   endfunction

   // ROM models: A registers once on enable, B adds two pipeline stages.
   logic [15:0] romAQ = '0;
   logic [15:0] romB0 = '0, romB1 = '0, romB2 = '0;
   always @(posedge clk) begin
      if (busA.rom_en) romAQ <= romWord(int'(busA.rom_addr));
      if (busB.rom_en) romB0 <= romWord(int'(busB.rom_addr));
      romB1 <= romB0;
      romB2 <= romB1;
   end
   assign busA.rom_data = romAQ;
   assign busB.rom_data = romB2;

   int rsp0CntA = 0, rsp1CntA = 0;
   always @(posedge clk) begin
      if (busA.rsp0_valid) rsp0CntA <= rsp0CntA + 1;
      if (busA.rsp1_valid) rsp1CntA <= rsp1CntA + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalCnt++;
      if (got !== exp) begin
         badCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base0, base1;
      busA.req0_valid = 0; busA.req1_valid = 0; busA.req0_addr = 0; busA.req1_addr = 0;
      busB.req0_valid = 0; busB.req1_valid = 0; busB.req0_addr = 0; busB.req1_addr = 0;
      step(3);
      check("rst_busy",  busA.busy, 0);
      check("rst_romen", busA.rom_en, 0);
      check("rst_addr",  busA.rom_addr, 0);
      check("rst_data",  busA.rsp_data, 0);
      check("rst_acks",  {busA.req0_ack, busA.req1_ack}, 0);
      check("rst_rsps",  {busA.rsp0_valid, busA.rsp1_valid}, 0);
      check("rstB_busy", busB.busy, 0);
      rst = 1;
      step(2);

      // ROM latency 3: single req0 addr 1
      busB.req0_valid = 1; busB.req0_addr = 3'd1;
      step();
      check("L3_ack0",  busB.req0_ack, 1);
      check("L3_romen", busB.rom_en, 1);
      check("L3_addr",  busB.rom_addr, 1);
      check("L3_busy1", busB.busy, 1);
      busB.req0_valid = 0;
      for (int i = 2; i <= 5; i++) begin
         step();
         check($sformatf("L3_busy%0d", i), busB.busy, 1);
         check($sformatf("L3_rsp0_%0d", i), busB.rsp0_valid, (i == 5));
      end
      check("L3_data", busB.rsp_data, romWord(1));
      check("L3_rsp1", busB.rsp1_valid, 0);
      step();
      check("L3_idle", busB.busy, 0);

      // Single req1 addr 5, latency 1
      base0 = rsp0CntA; base1 = rsp1CntA;
      busA.req1_valid = 1; busA.req1_addr = 3'd5;
      step();
      check("s1_ack1",  busA.req1_ack, 1);
      check("s1_ack0",  busA.req0_ack, 0);
      check("s1_romen", busA.rom_en, 1);
      check("s1_addr",  busA.rom_addr, 5);
      busA.req1_valid = 0;
      step();
      check("s1_romen_off", busA.rom_en, 0);
      check("s1_ack_off",   busA.req1_ack, 0);
      check("s1_rsp_early", busA.rsp1_valid, 0);
      step();
      check("s1_rsp1", busA.rsp1_valid, 1);
      check("s1_data", busA.rsp_data, 16'h1234);
      step();
      check("s1_rsp_off", busA.rsp1_valid, 0);
      check("s1_idle",    busA.busy, 0);
      check("s1_hold",    busA.rsp_data, 16'h1234);
      check("s1_no_rsp0", 32'(rsp0CntA - base0), 0);
      check("s1_one_rsp1", 32'(rsp1CntA - base1), 1);

      // Request during busy: req1 addr 6, then req0 addr 1 raised in WAIT
      busA.req1_valid = 1; busA.req1_addr = 3'd6;
      step();
      check("bz_ack1", busA.req1_ack, 1);
      busA.req1_valid = 0;
      step();
      busA.req0_valid = 1; busA.req0_addr = 3'd1;
      step();
      check("bz_rsp1", busA.rsp1_valid, 1);
      check("bz_data1", busA.rsp_data, romWord(6));
      check("bz_noack", busA.req0_ack, 0);
      step();
      check("bz_idle", busA.busy, 0);
      check("bz_noack2", busA.req0_ack, 0);
      step();
      check("bz_ack0", busA.req0_ack, 1);
      check("bz_addr", busA.rom_addr, 1);
      busA.req0_valid = 0;
      step();
      check("bz_hold", busA.rsp_data, romWord(6));
      step();
      check("bz_rsp0", busA.rsp0_valid, 1);
      check("bz_data0", busA.rsp_data, romWord(1));
      step();

      // Simultaneous requests from reset: addr0 2, addr1 6
      rst = 0;
      busA.req0_valid = 1; busA.req0_addr = 3'd2;
      busA.req1_valid = 1; busA.req1_addr = 3'd6;
      step();
      rst = 1;
      step();
      check("sim_ack0", busA.req0_ack, 1);
      check("sim_ack1_no", busA.req1_ack, 0);
      check("sim_addr0", busA.rom_addr, 2);
      busA.req0_valid = 0;
      step(2);
      check("sim_rsp0", busA.rsp0_valid, 1);
      check("sim_data0", busA.rsp_data, romWord(2));
      step();
      check("sim_ack1_wait", busA.req1_ack, 0);
      step();
      check("sim_ack1", busA.req1_ack, 1);
      check("sim_addr1", busA.rom_addr, 6);
      busA.req1_valid = 0;
      step(2);
      check("sim_rsp1", busA.rsp1_valid, 1);
      check("sim_data1", busA.rsp_data, romWord(6));
      step();

      // Tie with requester 0 re-requesting straight after its response
      busA.req0_valid = 1; busA.req0_addr = 3'd3;
      busA.req1_valid = 1; busA.req1_addr = 3'd4;
      step();
      check("rr_first_ack0", busA.req0_ack, 1);
      busA.req0_valid = 0;
      step(2);
      check("rr_first_rsp0", busA.rsp0_valid, 1);
      busA.req0_valid = 1; busA.req0_addr = 3'd7;
      step(2);
`ifdef ROM_ARB_RR_EN
      check("rr_second_ack1", busA.req1_ack, 1);
      check("rr_second_addr", busA.rom_addr, 4);
      busA.req1_valid = 0;
      step(2);
      check("rr_second_rsp1", busA.rsp1_valid, 1);
      check("rr_second_data", busA.rsp_data, romWord(4));
      step(2);
      check("rr_third_ack0", busA.req0_ack, 1);
      check("rr_third_addr", busA.rom_addr, 7);
      busA.req0_valid = 0;
`else
      check("fp_second_ack0", busA.req0_ack, 1);
      check("fp_second_ack1", busA.req1_ack, 0);
      check("fp_second_addr", busA.rom_addr, 7);
      busA.req0_valid = 0;
      step(2);
      check("fp_second_rsp0", busA.rsp0_valid, 1);
      check("fp_second_data", busA.rsp_data, romWord(7));
      step(2);
      check("fp_third_ack1", busA.req1_ack, 1);
      check("fp_third_addr", busA.rom_addr, 4);
      busA.req1_valid = 0;
`endif
      step(4);
      check("tie_idle", busA.busy, 0);

      // Reset asserted during WAIT
      busA.req0_valid = 1; busA.req0_addr = 3'd2;
      step();
      check("rw_ack0", busA.req0_ack, 1);
      busA.req0_valid = 0;
      step();
      check("rw_inwait", busA.busy, 1);
      #2 rst = 0;
      #1;
      check("rw_busy",  busA.busy, 0);
      check("rw_romen", busA.rom_en, 0);
      check("rw_addr",  busA.rom_addr, 0);
      check("rw_data",  busA.rsp_data, 0);
      check("rw_rsps",  {busA.rsp0_valid, busA.rsp1_valid}, 0);
      base0 = rsp0CntA; base1 = rsp1CntA;
      step();
      rst = 1;
      step(5);
      check("rw_no_rsp", 32'((rsp0CntA - base0) + (rsp1CntA - base1)), 0);
      busA.req1_valid = 1; busA.req1_addr = 3'd5;
      step();
      check("rw_fresh_ack1", busA.req1_ack, 1);
      busA.req1_valid = 0;
      step(2);
      check("rw_fresh_rsp1", busA.rsp1_valid, 1);
      check("rw_fresh_data", busA.rsp_data, 16'h1234);
      step(2);

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end
endmodule
